bpm_line_writer: RTL and testbench

BPM_LINE_WRITER -- requirements
Module: bpm_line_writer

---
 rtl/bpm_line_writer_pkg.sv | 41 ++++
 rtl/bpm_divider.sv | 55 +++++
 rtl/bpm_line_writer.sv | 160 ++++++++++++++++
 tb/tb_bpm_line_writer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bpm_line_writer_pkg.sv
// Shared constants, state encoding and helpers for the BPM line writer.
// The display line is 16 ASCII characters with character 0 in the top byte.
package bpm_line_writer_pkg;

  localparam logic [7:0]  ASCII_SPACE = 8'h20;
  localparam logic [7:0]  ASCII_DASH  = 8'h2D;
  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [31:0] ASCII_BPM   = 32'h42504D20;   // "BPM "

  localparam logic [15:0] BPM_NUMERATOR = 16'd60000;   // ms per minute
  localparam int DIV_DW    = 16;
  localparam int DIV_VW    = 12;
  localparam int BCD_STEPS = 9;

  typedef enum logic [2:0] {IDLE, MEASURE, DIVIDE, BCD, WRITE} state_t;

  typedef struct packed {
    logic [DIV_DW-1:0] dividend;
    logic [DIV_VW-1:0] divisor;
  } div_req_t;

  localparam logic [127:0] TIMEOUT_LINE = {ASCII_BPM, {3{ASCII_DASH}}, {9{ASCII_SPACE}}};

  function automatic logic [127:0] bpm_line(input logic [11:0] bcd);
    return {ASCII_BPM,
            ASCII_ZERO | {4'd0, bcd[11:8]},
            ASCII_ZERO | {4'd0, bcd[7:4]},
            ASCII_ZERO | {4'd0, bcd[3:0]},
            {9{ASCII_SPACE}}};
  endfunction

  // One double-dabble step: correct digits >= 5, then shift in the next binary bit.
  function automatic logic [11:0] bcd_shift_add3(input logic [11:0] bcd, input logic bit_in);
    logic [11:0] adj;
    adj = bcd;
    for (int d = 0; d < 3; d++)
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    return {adj[10:0], bit_in};
  endfunction

endpackage

// File: rtl/bpm_divider.sv
// Sequential restoring divider: one quotient bit per clock, DIV_DW clocks per divide.
// done is high during the final iteration; quotient is valid from the following cycle.
module bpm_divider
  import bpm_line_writer_pkg::*;
#(
  parameter int QW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  div_req_t      req,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(DIV_DW);

  logic              busy;
  logic [CW-1:0]     cnt;
  logic [DIV_VW-1:0] rem;
  logic [DIV_VW-1:0] dvs;
  logic [DIV_DW-1:0] quo;
  logic [DIV_VW:0]   rem_sh;
  logic [DIV_VW-1:0] diff;
  logic              fit;

  assign rem_sh   = {rem, quo[DIV_DW-1]};
  assign fit      = rem_sh >= {1'b0, dvs};
  // Remainder after subtraction is below the divisor, so the low bits suffice.
  assign diff     = rem_sh[DIV_VW-1:0] - dvs;
  assign done     = busy && (cnt == CW'(DIV_DW - 1));
  assign quotient = quo[QW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dvs  <= '0;
      quo  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      dvs  <= req.divisor;
      quo  <= req.dividend;
    end else if (busy) begin
      rem <= fit ? diff : rem_sh[DIV_VW-1:0];
      quo <= {quo[DIV_DW-2:0], fit};
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/bpm_line_writer.sv
// Measures heartbeat intervals in ms, converts to BPM (60000/period) in BCD and
// writes a 16-char text line into a 4-entry line RAM; silence yields "BPM ---".
module bpm_line_writer
  import bpm_line_writer_pkg::*;
#(
  parameter int TICK_CYC = 25000,
  parameter int MIN_MS   = 200,
  parameter int MAX_MS   = 3000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beat_in,
  output logic         ram_we,
  output logic [1:0]   ram_addr,
  output logic [127:0] ram_din,
  output logic [1:0]   newest_addr,
  output logic [11:0]  bpm_bcd
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [11:0] MIN_P = 12'(MIN_MS);
  localparam logic [11:0] MAX_P = 12'(MAX_MS);

  state_t        state, state_n;
  logic          sync1, sync2, sync3, beat_pulse;
  logic          pending, beat;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [11:0]   period_ms;
  logic          clr_period, div_start, div_done, bcd_fin, load_to;
  logic          timeout_line;
  logic [3:0]    bcd_cnt;
  logic [11:0]   bcd_acc, bcd_step;
  logic [8:0]    quotient;
  logic [1:0]    wr_ptr;
  div_req_t      div_req;

  assign tick     = (tick_cnt == TW'(TICK_CYC - 1));
  assign beat     = beat_pulse | pending;
  assign div_req  = '{dividend: BPM_NUMERATOR, divisor: period_ms};
  // Quotient is consumed MSB first straight from the idle divider.
  assign bcd_step = bcd_shift_add3(bcd_acc, quotient[4'(BCD_STEPS - 1) - bcd_cnt]);

  bpm_divider #(.QW(9)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .req      (div_req),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      beat_pulse <= 1'b0;
    end else begin
      sync1      <= beat_in;
      sync2      <= sync1;
      sync3      <= sync2;
      beat_pulse <= sync2 & ~sync3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tick_cnt <= '0;
    else       tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // The clearing edge still counts its own tick so an N ms gap measures exactly N.
  always_ff @(posedge clk) begin
    if (reset)                          period_ms <= '0;
    else if (clr_period)                period_ms <= {11'd0, tick};
    else if (tick && period_ms < MAX_P) period_ms <= period_ms + 12'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)                               pending <= 1'b0;
    else if (state == IDLE || state == MEASURE) pending <= 1'b0;
    else if (beat_pulse)                     pending <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    clr_period = 1'b0;
    div_start  = 1'b0;
    bcd_fin    = 1'b0;
    load_to    = 1'b0;
    case (state)
      IDLE: begin
        if (beat) begin
          clr_period = 1'b1;
          state_n    = MEASURE;
        end
      end
      MEASURE: begin
        if (period_ms >= MAX_P) begin
          load_to = 1'b1;
          state_n = WRITE;
        end else if (beat && period_ms >= MIN_P) begin
          clr_period = 1'b1;
          div_start  = 1'b1;
          state_n    = DIVIDE;
        end
      end
      DIVIDE: if (div_done) state_n = BCD;
      BCD: begin
        if (bcd_cnt == 4'(BCD_STEPS - 1)) begin
          bcd_fin = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE:   state_n = timeout_line ? IDLE : MEASURE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_acc      <= '0;
      bcd_cnt      <= '0;
      bpm_bcd      <= '0;
      ram_din      <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      newest_addr  <= '0;
      wr_ptr       <= '0;
      timeout_line <= 1'b0;
    end else begin
      if (div_done) begin
        bcd_acc <= '0;
        bcd_cnt <= '0;
      end else if (state == BCD) begin
        bcd_acc <= bcd_step;
        bcd_cnt <= bcd_cnt + 4'd1;
      end
      if (bcd_fin) begin
        bpm_bcd <= bcd_step;
        ram_din <= bpm_line(bcd_step);
      end else if (load_to) begin
        ram_din <= TIMEOUT_LINE;
      end
      ram_we <= (state_n == WRITE);
      if (state_n == WRITE) begin
        ram_addr     <= wr_ptr;
        newest_addr  <= wr_ptr;
        wr_ptr       <= wr_ptr + 2'd1;
        timeout_line <= load_to;
      end
    end
  end

endmodule

// File: tb/tb_bpm_line_writer.sv
// Directed/random heartbeat sequences checked against a ms-level model of the line writer.
module tb_bpm_line_writer;

  logic         clk = 1'b0;
  logic         reset;
  logic         beat_in;
  logic         ram_we;
  logic [1:0]   ram_addr;
  logic [127:0] ram_din;
  logic [1:0]   newest_addr;
  logic [11:0]  bpm_bcd;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          nwr   = 0;
  logic [11:0] last_bcd = '0;

  always #5 clk = ~clk;

  bpm_line_writer #(.TICK_CYC(10), .MIN_MS(200), .MAX_MS(3000)) dut (
    .clk         (clk),
    .reset       (reset),
    .beat_in     (beat_in),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .newest_addr (newest_addr),
    .bpm_bcd     (bpm_bcd)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bpm < 0 gives the timeout line
  function automatic logic [127:0] line_of(input int bpm);
    string s;
    logic [127:0] v;
    s = (bpm < 0) ? "BPM ---" : $sformatf("BPM %03d", bpm);
    for (int i = 0; i < 16; i++) v[127-8*i -: 8] = (i < 7) ? s[i] : 8'h20;
    return v;
  endfunction

  function automatic logic [11:0] bcd_of(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic wait_ms(input int ms);
    repeat (ms * 10 - 40) @(negedge clk);
  endtask

  // Raise beat_in, watch 40 clocks. exp_bpm > 0: one write 28 clocks after the
  // first sampling edge; exp_bpm == 0: no write at all.
  task automatic beat(input int exp_bpm);
    int hits, at;
    logic [1:0]   ga, gn;
    logic [127:0] gd;
    logic [11:0]  gb;
    hits = 0; at = -1; ga = '0; gn = '0; gd = '0; gb = '0;
    beat_in = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 5) beat_in = 1'b0;
      if (ram_we) begin
        hits++;
        if (at < 0) begin
          at = k; ga = ram_addr; gn = newest_addr; gd = ram_din; gb = bpm_bcd;
        end
      end
    end
    if (exp_bpm > 0) begin
      chk($sformatf("writes_%0d", exp_bpm), 128'(hits), 128'd1);
      chk($sformatf("latency_%0d", exp_bpm), 128'(at), 128'd28);
      chk($sformatf("ram_addr_%0d", exp_bpm), 128'(ga), 128'(nwr % 4));
      chk($sformatf("newest_addr_%0d", exp_bpm), 128'(gn), 128'(nwr % 4));
      chk($sformatf("ram_din_%0d", exp_bpm), gd, line_of(exp_bpm));
      chk($sformatf("bpm_bcd_%0d", exp_bpm), 128'(gb), 128'(bcd_of(exp_bpm)));
      nwr++;
      last_bcd = bcd_of(exp_bpm);
    end else begin
      chk("no_write", 128'(hits), 128'd0);
    end
  endtask

  // Silence after the last beat: one timeout line about 3000 ms after it.
  task automatic timeout_check();
    int hits, at;
    logic [1:0]   ga, gn;
    logic [127:0] gd;
    logic [11:0]  gb;
    hits = 0; at = -1; ga = '0; gn = '0; gd = '0; gb = '0;
    for (int k = 0; k < 30100; k++) begin
      @(negedge clk);
      if (ram_we) begin
        hits++;
        if (at < 0) begin
          at = k + 40; ga = ram_addr; gn = newest_addr; gd = ram_din; gb = bpm_bcd;
        end
      end
    end
    chk("to_writes", 128'(hits), 128'd1);
    chk("to_time_ok", 128'(at >= 29990 && at <= 30010), 128'd1);
    chk("to_ram_addr", 128'(ga), 128'(nwr % 4));
    chk("to_newest", 128'(gn), 128'(nwr % 4));
    chk("to_ram_din", gd, line_of(-1));
    chk("to_bpm_bcd", 128'(gb), 128'(last_bcd));
    nwr++;
  endtask

  // Reset while the divider is running: everything clears, nothing is written.
  task automatic reset_in_divide();
    int hits;
    hits = 0;
    beat_in = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    beat_in = 1'b0;
    @(negedge clk);
    chk("rst_div_ram_we", 128'(ram_we), 128'd0);
    chk("rst_div_ram_addr", 128'(ram_addr), 128'd0);
    chk("rst_div_ram_din", ram_din, 128'd0);
    chk("rst_div_newest", 128'(newest_addr), 128'd0);
    chk("rst_div_bpm_bcd", 128'(bpm_bcd), 128'd0);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ram_we) hits++;
    end
    chk("rst_div_no_write", 128'(hits), 128'd0);
    nwr = 0;
    last_bcd = '0;
  endtask

  initial begin
    int g;
    reset = 1'b1;
    beat_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_we", 128'(ram_we), 128'd0);
    chk("rst_ram_addr", 128'(ram_addr), 128'd0);
    chk("rst_ram_din", ram_din, 128'd0);
    chk("rst_newest", 128'(newest_addr), 128'd0);
    chk("rst_bpm_bcd", 128'(bpm_bcd), 128'd0);
    reset = 1'b0;
    @(negedge clk);

    beat(0);
    wait_ms(1000); beat(60);
    wait_ms(750);  beat(80);
    wait_ms(300);  beat(200);
    wait_ms(150);  beat(0);
    wait_ms(650);  beat(75);
    wait_ms(200);  beat(300);
    for (int r = 0; r < 3; r++) begin
      g = int'($urandom_range(450, 200));
      wait_ms(g);
      beat(60000 / g);
    end

    timeout_check();
    beat(0);

    wait_ms(250);
    reset_in_divide();
    beat(0);
    wait_ms(400); beat(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
